// File: rtl/cpu_clk_seq_if.sv
// ============================================================================
// Module      : cpu_clk_seq_if
// Description : phi2 input, soft reset request and strobe/reset/status outputs
//               of the CPU clock sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_clk_seq_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 phi_in;
   logic                 cpu_rst_req;
   logic                 phi_rise;
   logic                 phi_fall;
   logic                 cpu_reset_n;
   logic [CNT_WIDTH-1:0] cycle_count;
   logic                 stalled;

   modport master (
      output phi_in,
      output cpu_rst_req,
      input  phi_rise,
      input  phi_fall,
      input  cpu_reset_n,
      input  cycle_count,
      input  stalled
   );

   modport slave (
      input  phi_in,
      input  cpu_rst_req,
      output phi_rise,
      output phi_fall,
      output cpu_reset_n,
      output cycle_count,
      output stalled
   );
endinterface

`default_nettype wire

// File: rtl/cpu_clk_seq.sv
// ============================================================================
// Module      : cpu_clk_seq
// Description : phi2 edge strobes, CPU reset sequencing, CPU cycle counter and
//               phi2 stall detection, all in the system clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_clk_seq #(
   parameter int RESET_CYCLES  = 8,
   parameter int STALL_TIMEOUT = 64,
   parameter int CNT_WIDTH     = 32
) (
   input  wire logic      clk,
   input  wire logic      reset_n,
   cpu_clk_seq_if.slave   bus
);

   localparam logic [7:0]  RCNT_MAX = 8'(RESET_CYCLES);
   localparam logic [15:0] SCNT_MAX = 16'(STALL_TIMEOUT);

   typedef enum logic [0:0] {
      HOLD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic                 phi_q;
   logic                 phi_rise_q, phi_rise_d;
   logic                 phi_fall_q, phi_fall_d;
   logic [7:0]           rcnt_q, rcnt_d;
   logic                 cpu_reset_n_q, cpu_reset_n_d;
   logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
   logic [15:0]          scnt_q, scnt_d;
   logic                 stalled_q, stalled_d;

   always_comb begin
      phi_rise_d    = bus.phi_in & ~phi_q;
      phi_fall_d    = ~bus.phi_in & phi_q;
      state_d       = state_q;
      rcnt_d        = rcnt_q;
      cpu_reset_n_d = cpu_reset_n_q;
      cycle_count_d = cycle_count_q;

      // A soft reset request overrides any edge seen in the same clock.
      if (bus.cpu_rst_req) begin
         state_d       = HOLD;
         rcnt_d        = 8'd0;
         cycle_count_d = '0;
         cpu_reset_n_d = 1'b0;
      end else begin
         case (state_q)
            HOLD: begin
               cpu_reset_n_d = 1'b0;
               if (phi_rise_d && (rcnt_q != RCNT_MAX)) begin
                  rcnt_d = rcnt_q + 8'd1;
               end
               if (phi_fall_d && (rcnt_q == RCNT_MAX)) begin
                  state_d       = RUN;
                  cpu_reset_n_d = 1'b1;
               end
            end
            RUN: begin
               cpu_reset_n_d = 1'b1;
               if (phi_rise_d) begin
                  cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_d       = HOLD;
               rcnt_d        = 8'd0;
               cpu_reset_n_d = 1'b0;
            end
         endcase
      end

      if (phi_rise_d || phi_fall_d) begin
         scnt_d = 16'd0;
      end else if (scnt_q != SCNT_MAX) begin
         scnt_d = scnt_q + 16'd1;
      end else begin
         scnt_d = scnt_q;
      end
      stalled_d = (scnt_d == SCNT_MAX);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phi_q         <= 1'b0;
         phi_rise_q    <= 1'b0;
         phi_fall_q    <= 1'b0;
         state_q       <= HOLD;
         rcnt_q        <= 8'd0;
         cpu_reset_n_q <= 1'b0;
         cycle_count_q <= '0;
         scnt_q        <= 16'd0;
         stalled_q     <= 1'b0;
      end else begin
         phi_q         <= bus.phi_in;
         phi_rise_q    <= phi_rise_d;
         phi_fall_q    <= phi_fall_d;
         state_q       <= state_d;
         rcnt_q        <= rcnt_d;
         cpu_reset_n_q <= cpu_reset_n_d;
         cycle_count_q <= cycle_count_d;
         scnt_q        <= scnt_d;
         stalled_q     <= stalled_d;
      end
   end

   assign bus.phi_rise    = phi_rise_q;
   assign bus.phi_fall    = phi_fall_q;
   assign bus.cpu_reset_n = cpu_reset_n_q;
   assign bus.cycle_count = cycle_count_q;
   assign bus.stalled     = stalled_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_clk_seq.sv
// ============================================================================
// Module      : tb_cpu_clk_seq
// Description : Directed bench for cpu_clk_seq (default and 4-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_clk_seq;

   logic clk;
   logic reset_n;
   logic phi_in;
   logic cpu_rst_req;
   int   n_cmp;
   int   n_bad;

   cpu_clk_seq_if #(.CNT_WIDTH(32)) bus  ();
   cpu_clk_seq_if #(.CNT_WIDTH(4))  bus4 ();

   assign bus.phi_in       = phi_in;
   assign bus.cpu_rst_req  = cpu_rst_req;
   assign bus4.phi_in      = phi_in;
   assign bus4.cpu_rst_req = cpu_rst_req;

   cpu_clk_seq #(.RESET_CYCLES(8), .STALL_TIMEOUT(64), .CNT_WIDTH(32)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   cpu_clk_seq #(.RESET_CYCLES(8), .STALL_TIMEOUT(64), .CNT_WIDTH(4)) u_dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus4.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One phi2 period; cpu_reset_n must read rst_pre through the high phase
   // and rst_post from the falling-edge strobe onward.
   task automatic run_period(input int hi, input int lo, input logic rst_pre, input logic rst_post);
      phi_in = 1'b1;
      for (int i = 0; i < hi; i++) begin
         tick();
         n_cmp++;
         if (bus.phi_rise !== (i == 0) || bus.phi_fall !== 1'b0) begin
            n_bad++;
            $display("FAIL rise_strobe t%0d: rise=%b fall=%b want rise=%b fall=0", i, bus.phi_rise, bus.phi_fall, (i == 0));
         end
         n_cmp++;
         if (bus.cpu_reset_n !== rst_pre || bus.stalled !== 1'b0) begin
            n_bad++;
            $display("FAIL hi_status t%0d: cpu_reset_n=%b stalled=%b want %b/0", i, bus.cpu_reset_n, bus.stalled, rst_pre);
         end
      end
      phi_in = 1'b0;
      for (int i = 0; i < lo; i++) begin
         tick();
         n_cmp++;
         if (bus.phi_fall !== (i == 0) || bus.phi_rise !== 1'b0) begin
            n_bad++;
            $display("FAIL fall_strobe t%0d: rise=%b fall=%b want rise=0 fall=%b", i, bus.phi_rise, bus.phi_fall, (i == 0));
         end
         n_cmp++;
         if (bus.cpu_reset_n !== rst_post || bus.stalled !== 1'b0) begin
            n_bad++;
            $display("FAIL lo_status t%0d: cpu_reset_n=%b stalled=%b want %b/0", i, bus.cpu_reset_n, bus.stalled, rst_post);
         end
      end
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      phi_in      = 1'b0;
      cpu_rst_req = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({bus.phi_rise, bus.phi_fall, bus.cpu_reset_n, bus.stalled} !== 4'b0000 || bus.cycle_count !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_values: rise/fall/rstn/stall=%b%b%b%b count=%0d want 0000 0",
                  bus.phi_rise, bus.phi_fall, bus.cpu_reset_n, bus.stalled, bus.cycle_count);
      end
      reset_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_powerup();
      for (int p = 1; p <= 8; p++) begin
         run_period(25, 25, 1'b0, (p == 8));
      end
      n_cmp++;
      if (bus.cycle_count !== 32'd0) begin
         n_bad++;
         $display("FAIL powerup_count: got %0d want 0", bus.cycle_count);
      end
   endtask

   task automatic test_run();
      for (int p = 0; p < 100; p++) begin
         run_period(25, 25, 1'b1, 1'b1);
      end
      n_cmp++;
      if (bus.cycle_count !== 32'd100) begin
         n_bad++;
         $display("FAIL run_count: got %0d want 100", bus.cycle_count);
      end
      n_cmp++;
      if (bus4.cycle_count !== 4'd4) begin
         n_bad++;
         $display("FAIL run_count4: got %0d want 4", bus4.cycle_count);
      end
   endtask

   task automatic test_rst_req();
      phi_in      = 1'b1;
      cpu_rst_req = 1'b1;
      tick();
      cpu_rst_req = 1'b0;
      n_cmp++;
      if (bus.cpu_reset_n !== 1'b0 || bus.cycle_count !== 32'd0 || bus.phi_rise !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_req_apply: rstn=%b count=%0d rise=%b want 0 0 1", bus.cpu_reset_n, bus.cycle_count, bus.phi_rise);
      end
      repeat (24) tick();
      phi_in = 1'b0;
      repeat (25) tick();
      n_cmp++;
      if (bus.cpu_reset_n !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_req_hold: cpu_reset_n=%b want 0", bus.cpu_reset_n);
      end
      for (int p = 1; p <= 7; p++) begin
         run_period(25, 25, 1'b0, 1'b0);
      end
      run_period(25, 25, 1'b0, 1'b1);
      n_cmp++;
      if (bus.cycle_count !== 32'd0) begin
         n_bad++;
         $display("FAIL rst_req_count: got %0d want 0", bus.cycle_count);
      end
   endtask

   task automatic test_stall();
      phi_in = 1'b1;
      repeat (25) tick();
      phi_in = 1'b0;
      tick();
      n_cmp++;
      if (bus.phi_fall !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_fall: phi_fall=%b want 1", bus.phi_fall);
      end
      for (int i = 1; i < 200; i++) begin
         tick();
         n_cmp++;
         if (bus.stalled !== (i >= 64)) begin
            n_bad++;
            $display("FAIL stall_timing t%0d: stalled=%b want %b", i, bus.stalled, (i >= 64));
         end
      end
      phi_in = 1'b1;
      tick();
      n_cmp++;
      if (bus.phi_rise !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_rise: phi_rise=%b want 1", bus.phi_rise);
      end
      tick();
      n_cmp++;
      if (bus.stalled !== 1'b0 || bus.cpu_reset_n !== 1'b1 || bus.cycle_count !== 32'd2) begin
         n_bad++;
         $display("FAIL stall_clear: stalled=%b rstn=%b count=%0d want 0 1 2", bus.stalled, bus.cpu_reset_n, bus.cycle_count);
      end
      repeat (23) tick();
      phi_in = 1'b0;
      repeat (25) tick();
   endtask

   task automatic test_async_reset();
      phi_in = 1'b1;
      tick();
      #4;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.phi_rise, bus.phi_fall, bus.cpu_reset_n, bus.stalled} !== 4'b0000 || bus.cycle_count !== 32'd0) begin
         n_bad++;
         $display("FAIL async_reset: rise/fall/rstn/stall=%b%b%b%b count=%0d want 0000 0",
                  bus.phi_rise, bus.phi_fall, bus.cpu_reset_n, bus.stalled, bus.cycle_count);
      end
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      n_cmp++;
      if (bus.phi_rise !== 1'b1 || bus.cpu_reset_n !== 1'b0) begin
         n_bad++;
         $display("FAIL release_rise: phi_rise=%b rstn=%b want 1 0", bus.phi_rise, bus.cpu_reset_n);
      end
      repeat (20) tick();
      phi_in = 1'b0;
      repeat (25) tick();
      n_cmp++;
      if (bus.cpu_reset_n !== 1'b0) begin
         n_bad++;
         $display("FAIL release_hold: cpu_reset_n=%b want 0", bus.cpu_reset_n);
      end
      for (int p = 1; p <= 6; p++) begin
         run_period(25, 25, 1'b0, 1'b0);
      end
      run_period(25, 25, 1'b0, 1'b1);
      n_cmp++;
      if (bus.cycle_count !== 32'd0 || bus4.cpu_reset_n !== 1'b1) begin
         n_bad++;
         $display("FAIL release_run: count=%0d rstn4=%b want 0 1", bus.cycle_count, bus4.cpu_reset_n);
      end
   endtask

   task automatic test_wrap();
      for (int p = 0; p < 15; p++) begin
         run_period(25, 25, 1'b1, 1'b1);
      end
      n_cmp++;
      if (bus4.cycle_count !== 4'd15) begin
         n_bad++;
         $display("FAIL wrap_15: got %0d want 15", bus4.cycle_count);
      end
      run_period(25, 25, 1'b1, 1'b1);
      n_cmp++;
      if (bus4.cycle_count !== 4'd0) begin
         n_bad++;
         $display("FAIL wrap_0: got %0d want 0", bus4.cycle_count);
      end
      run_period(25, 25, 1'b1, 1'b1);
      run_period(25, 25, 1'b1, 1'b1);
      n_cmp++;
      if (bus4.cycle_count !== 4'd2 || bus.cycle_count !== 32'd18) begin
         n_bad++;
         $display("FAIL wrap_2: count4=%0d count=%0d want 2 18", bus4.cycle_count, bus.cycle_count);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_powerup();
      test_run();
      test_rst_req();
      test_stall();
      test_async_reset();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
